// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation p^n (n = 1..12) with UNROLL rounds per clock and
// valid/ready handshakes on both the request and result sides.
module ascon_perm_engine #(
   parameter int unsigned UNROLL       = 1,
   parameter bit          CLAMP_ROUNDS = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [319:0] in_state,
   input  logic [3:0]   in_rounds,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic         busy
);

   localparam logic [3:0] LastIdx = 4'd12;
   localparam logic [3:0] UnrollW = 4'(UNROLL);

   typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

   fsm_e         st_q, st_d;
   logic [319:0] state_q, state_d;
   logic [3:0]   r_q, r_d;

   logic         accept;
   logic [3:0]   n_eff;
   logic [3:0]   src_r;
   logic [3:0]   rem;
   logic [3:0]   k;
   logic [3:0]   r_next;
   logic [319:0] src_state;
   logic [319:0] chain_out;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned a);
      return (x >> a) | (x << (64 - a));
   endfunction

   function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128];
      x3 = s[127:64];
      x4 = s[63:0];
      x2[7:0] = x2[7:0] ^ {4'd15 - r, r};
      // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once.
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   assign in_ready  = (st_q == StIdle) || ((st_q == StDone) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (st_q == StDone);
   assign busy      = (st_q == StRun);
   assign out_state = state_q;

   always_comb begin
      n_eff = in_rounds;
      if ((in_rounds == 4'd0) || (in_rounds > LastIdx)) begin
         n_eff = CLAMP_ROUNDS ? LastIdx : 4'd0;
      end
   end

   // The accept cycle already runs its first batch of rounds on in_state, so a
   // job occupies exactly ceil(n / UNROLL) cycles and n = 0 lands in DONE at once.
   assign src_state = accept ? in_state : state_q;
   assign src_r     = accept ? (LastIdx - n_eff) : r_q;
   assign rem       = LastIdx - src_r;
   assign k         = (rem > UnrollW) ? UnrollW : rem;
   assign r_next    = src_r + k;

   for (genvar j = 0; j < UNROLL; j++) begin : g_stage
      logic [319:0] s_in;
      logic [319:0] s_out;
      if (j == 0) begin : g_first
         assign s_in = src_state;
      end else begin : g_next
         assign s_in = g_stage[j-1].s_out;
      end
      assign s_out = (4'(j) < k) ? round_fn(s_in, src_r + 4'(j)) : s_in;
   end

   assign chain_out = g_stage[UNROLL-1].s_out;

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      r_d     = r_q;
      if (accept || (st_q == StRun)) begin
         state_d = chain_out;
         r_d     = r_next;
         st_d    = (r_next == LastIdx) ? StDone : StRun;
      end else if ((st_q == StDone) && out_ready) begin
         st_d = StIdle;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= StIdle;
         state_q <= '0;
         r_q     <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         r_q     <= r_d;
      end
   end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench for ascon_perm_engine: four configurations driven from a vector table,
// plus reset, back-pressure and streaming sequences against a table-based model.
module tb_ascon_perm_engine;

   localparam logic [255:0] SBOX_HEX = {
      8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
      8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
      8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
      8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

   typedef struct packed {
      logic [319:0]   st;
      logic [3:0]     rounds;
      logic [3:0][4:0] lat;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [319:0] in_state;
   logic [3:0]   in_rounds;
   logic         iv   [4];
   logic         ordy [4];
   logic         ir   [4];
   logic         ov   [4];
   logic         bz   [4];
   logic [319:0] os   [4];

   int un [4] = '{1, 2, 4, 6};
   bit cl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ascon_perm_engine #(.UNROLL(1), .CLAMP_ROUNDS(1'b1)) u_e0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]),
      .busy(bz[0]));
   ascon_perm_engine #(.UNROLL(2), .CLAMP_ROUNDS(1'b0)) u_e1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]),
      .busy(bz[1]));
   ascon_perm_engine #(.UNROLL(4), .CLAMP_ROUNDS(1'b1)) u_e2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]),
      .busy(bz[2]));
   ascon_perm_engine #(.UNROLL(6), .CLAMP_ROUNDS(1'b0)) u_e3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov[3]), .out_ready(ordy[3]), .out_state(os[3]),
      .busy(bz[3]));

   function automatic logic [63:0] ror(input logic [63:0] x, input int a);
      logic [127:0] d;
      d = {x, x} >> a;
      return d[63:0];
   endfunction

   function automatic logic [319:0] model(input logic [319:0] s, input int n);
      logic [63:0]  x [5];
      logic [63:0]  y [5];
      logic [255:0] tbl;
      logic [4:0]   col;
      logic [7:0]   ent;
      tbl = SBOX_HEX;
      for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
      for (int r = 12 - n; r < 12; r++) begin
         x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            ent = tbl[(31 - int'(col))*8 +: 8];
            for (int i = 0; i < 5; i++) y[i][b] = ent[4-i];
         end
         x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
         x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
         x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
         x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
         x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic int eff(input logic [3:0] rounds, input bit clamp);
      if (rounds == 4'd0 || rounds > 4'd12) return clamp ? 12 : 0;
      return int'(rounds);
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic vec_t mkv(input logic [319:0] st, input logic [3:0] rounds,
                                input int l0, input int l1, input int l2, input int l3);
      vec_t v;
      v.st     = st;
      v.rounds = rounds;
      v.lat[0] = 5'(l0);
      v.lat[1] = 5'(l1);
      v.lat[2] = 5'(l2);
      v.lat[3] = 5'(l3);
      return v;
   endfunction

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      int  lat [4];
      bool_all: begin end
      in_state  = v.st;
      in_rounds = v.rounds;
      for (int i = 0; i < 4; i++) begin
         iv[i]   = 1'b1;
         ordy[i] = 1'b0;
         lat[i]  = 0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) iv[i] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         bit all_done;
         all_done = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (lat[i] == 0 && ov[i]) lat[i] = c;
            if (lat[i] == 0) all_done = 1'b0;
         end
         if (all_done) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         chk_int($sformatf("vec%0d_u%0d_latency", vi, un[i]), lat[i], int'(v.lat[i]));
         chk($sformatf("vec%0d_u%0d_state", vi, un[i]), os[i],
             model(v.st, eff(v.rounds, cl[i])));
      end
      for (int i = 0; i < 4; i++) ordy[i] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         ordy[i] = 1'b0;
         chk_int($sformatf("vec%0d_u%0d_drained", vi, un[i]), int'(ov[i]), 0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", nchk, nerr);
      $fatal(1);
   end

   initial begin
      vec_t         vt [10];
      logic [319:0] sa, sb, exp_a;
      logic [319:0] q [$];
      int           bad, got, cyc, first, last, sum_l, idx, e;
      bit           acc, con, seen;

      vt[0] = mkv('0,         4'd1,  1,  1, 1, 1);
      vt[1] = mkv(rnd320(),   4'd12, 12, 6, 3, 2);
      vt[2] = mkv(rnd320(),   4'd8,  8,  4, 2, 2);
      vt[3] = mkv(rnd320(),   4'd6,  6,  3, 2, 1);
      vt[4] = mkv(rnd320(),   4'd0,  12, 1, 3, 1);
      vt[5] = mkv(rnd320(),   4'd15, 12, 1, 3, 1);
      vt[6] = mkv(rnd320(),   4'd5,  5,  3, 2, 1);
      vt[7] = mkv(rnd320(),   4'd3,  3,  2, 1, 1);
      vt[8] = mkv({320{1'b1}}, 4'd12, 12, 6, 3, 2);
      vt[9] = mkv(rnd320(),   4'd13, 12, 1, 3, 1);

      rst       = 1'b1;
      in_state  = '0;
      in_rounds = '0;
      for (int i = 0; i < 4; i++) begin
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_u%0d_state", un[i]), os[i], '0);
         chk_int($sformatf("reset_u%0d_flags", un[i]), {ov[i], bz[i], ir[i]}, 1);
      end
      rst = 1'b0;

      // Reset mid-RUN on the single-round engine.
      in_state  = rnd320();
      in_rounds = 4'd12;
      iv[0]     = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk_int("midrun_busy", int'(bz[0]), 1);
      rst = 1'b1;
      #1;
      chk_int("midrun_reset_flags", {ov[0], bz[0], ir[0]}, 1);
      #2 rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov[0]) seen = 1'b1;
      end
      chk_int("midrun_no_output", int'(seen), 0);

      for (int v = 0; v < 10; v++) run_vec(vt[v], v);

      // Back-pressure on the UNROLL=4 engine.
      sa        = rnd320();
      exp_a     = model(sa, 12);
      in_state  = sa;
      in_rounds = 4'd12;
      iv[2]     = 1'b1;
      @(posedge clk); #1;
      iv[2] = 1'b0;
      for (int c = 0; c < 10 && !ov[2]; c++) begin
         @(posedge clk); #1;
      end
      chk_int("bp_done", int'(ov[2]), 1);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         in_state  = rnd320();
         in_rounds = 4'(c % 13);
         iv[2]     = c[0];
         @(posedge clk); #1;
         if (os[2] !== exp_a || ir[2] !== 1'b0 || ov[2] !== 1'b1) bad++;
      end
      chk_int("bp_hold_cycles_bad", bad, 0);
      chk("bp_hold_state", os[2], exp_a);
      sb        = rnd320();
      in_state  = sb;
      in_rounds = 4'd8;
      iv[2]     = 1'b1;
      ordy[2]   = 1'b1;
      #1;
      chk_int("bp_ready_same_cycle", int'(ir[2]), 1);
      @(posedge clk); #1;
      iv[2]   = 1'b0;
      ordy[2] = 1'b0;
      chk_int("bp_next_running", {ov[2], bz[2]}, 1);
      @(posedge clk); #1;
      chk_int("bp_next_done", int'(ov[2]), 1);
      chk("bp_next_state", os[2], model(sb, 8));
      ordy[2] = 1'b1;
      @(posedge clk); #1;
      ordy[2] = 1'b0;

      // Streaming on the UNROLL=2, non-clamping engine.
      idx       = 0;
      got       = 0;
      cyc       = 0;
      first     = -1;
      last      = -1;
      sum_l     = 0;
      in_state  = rnd320();
      in_rounds = 4'd3;
      iv[1]     = 1'b1;
      ordy[1]   = 1'b1;
      while (got < 50 && cyc < 2000) begin
         acc = ir[1] && iv[1];
         con = ov[1];
         if (con) begin
            if (q.size() == 0) begin
               chk_int("stream_spurious_result", 1, 0);
            end else begin
               chk($sformatf("stream_result%0d", got), os[1], q.pop_front());
            end
            got++;
            last = cyc;
         end
         if (acc) begin
            e = eff(in_rounds, 1'b0);
            q.push_back(model(in_state, e));
            sum_l += (e == 0) ? 1 : (e + 1) / 2;
            if (first < 0) first = cyc;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 50) begin
               in_state  = rnd320();
               in_rounds = 4'((idx * 7 + 3) % 16);
            end else begin
               iv[1] = 1'b0;
            end
         end
      end
      ordy[1] = 1'b0;
      chk_int("stream_count", got, 50);
      chk_int("stream_cycles", last - first, sum_l);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/ascon_perm_engine.md
Name: ascon_perm_engine

Overview:
- Iterative, parametrised ASCON permutation engine: applies p^n (n = 1..12 rounds, selectable per request) to a 320-bit state.
- Each round is constant addition, then 5-bit S-box layer, then linear diffusion.
- UNROLL rounds are computed per clock; a valid/ready handshake on each side lets it sit between the mode controller and the absorb/squeeze datapath.
- Successor to the single combinational round: adds sequencing, a variable round count, and back-pressure.

Parameters:
- UNROLL, 1, rounds evaluated per clock. Legal values: 1, 2, 3, 4, 6.
- CLAMP_ROUNDS, 1, if 1, an in_rounds value of 0 or >12 is treated as 12. If 0, it is treated as a pass-through (0 rounds).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  engine can accept a request
- in_state  input  320  x0 = [319:256], x1, x2, x3, x4 = [63:0]
- in_rounds  input  4  round count n
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_state  output  320  permuted state, same word order
- busy  output  1  computing (not idle, not holding a result)

Behaviour:
- Reset values: state register 0, round index 0, FSM IDLE, in_ready=1, out_valid=0, busy=0, out_state=0.
- Reset mid-computation aborts the job; nothing is emitted.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: busy=1.
  - DONE: out_valid=1, out_state held stable.
- Accept happens on in_valid & in_ready. On accept:
  - latch in_state;
  - set r = 12 − n (first constant index) and end index e = 12.
  - If n = 0 (pass-through), go directly to DONE with out_state = in_state. Latency is 1 cycle.
- Round constant for index r is c_r = ((15 − r) << 4) | r. It is XORed into the low byte of x2.
- S-box (x0 = MSB of the 5-bit column): 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- Linear diffusion, xi ^= (xi >>> a) ^ (xi >>> b), with (a, b):
  - x0: (19, 28)
  - x1: (61, 39)
  - x2: (1, 6)
  - x3: (10, 17)
  - x4: (7, 41)
- RUN, each cycle:
  - Apply k = min(UNROLL, e − r) rounds through a chain of UNROLL round stages.
  - A stage whose index is ≥ k is bypassed.
  - Then r += k. When r reaches e, go to DONE.
- Latency from the accept edge to out_valid = ceil(n / UNROLL) cycles. Example: n=12, UNROLL=4 → 3 cycles; n=6, UNROLL=4 → 2 cycles, the second with 2 stages bypassed.
- DONE:
  - Hold out_valid and out_state until out_ready.
  - out_valid & out_ready with no new request → IDLE.
- in_ready = IDLE | (DONE & out_ready). A new request may be accepted in the same cycle a result is consumed, which gives zero bubble.
- in_valid is ignored while RUN or while DONE without out_ready. Inputs are sampled only at accept.
- A change of in_state or in_rounds during RUN has no effect.
- out_state is registered, not combinational from the datapath.

Test Plan:
- Reset then idle: assert rst mid-RUN (UNROLL=1, n=12, after 5 cycles) → out_valid=0, busy=0, in_ready=1 immediately. No output ever emitted for that job.
- Golden p^12 / p^8 / p^6: random states (≥1000 per n) for each UNROLL ∈ {1, 2, 3, 4, 6} → out_state bit-exact to the reference C model. Latencies checked: 12/8/6 (UNROLL=1), 3/2/2 (UNROLL=4), 2/2/1 (UNROLL=6).
- Single round, all-zero input, n=1 → result equals the model's one round with c_11 = 0x4B. Latency 1.
- Pass-through: n=0 with CLAMP_ROUNDS=0 → out_state == in_state, 1 cycle. n=0 with CLAMP_ROUNDS=1 → identical to n=12. n=15 → identical to n=12 when clamped.
- Back-pressure: hold out_ready=0 for 20 cycles after DONE → out_state stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 together with in_valid=1 → new job accepted the same cycle, with no lost or duplicated result.
- Streaming: 50 back-to-back requests with out_ready=1 → throughput one result per ceil(n / UNROLL) + 0 cycles, results in order and matching the model.
